// File: rtl/mem_arbiter_if.sv
// Requester- and RAM-side control signals of the memory arbiter.
// slave: the arbiter itself; master: the fetch/LSU side that drives the requests.
interface mem_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);
  logic              ifReq;
  logic [AWIDTH-1:0] ifAddr;
  logic              ifAck;
  logic [DWIDTH-1:0] ifRdata;
  logic              dReq;
  logic              dWe;
  logic [AWIDTH-1:0] dAddr;
  logic [DWIDTH-1:0] dWdata;
  logic              dAck;
  logic [DWIDTH-1:0] dRdata;
  logic [AWIDTH-1:0] ramAddr;
  logic              ramRdEn;
  logic              ramWrEn;
  logic              busy;

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata,
    input  ifAck, ifRdata, dAck, dRdata, ramAddr, ramRdEn, ramWrEn, busy
  );

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata,
    output ifAck, ifRdata, dAck, dRdata, ramAddr, ramRdEn, ramWrEn, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store: IDLE -> ACCESS -> DONE.
// Define MEMARB_RR_EN for round-robin on ties; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  inout  wire  [DWIDTH-1:0] ramData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              gntD_q, gntD_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] ifRdata_q, ifRdata_d;
  logic [DWIDTH-1:0] dRdata_q, dRdata_d;
  logic              anyReq;
  logic              pickD;

`ifdef MEMARB_RR_EN
  logic              rrD_q, rrD_d;

  // rrD_q=1 means the data port wins the next tie.
  always_comb pickD = bus.dReq && (!bus.ifReq || rrD_q);
`else
  always_comb pickD = bus.dReq;
`endif

  assign anyReq = bus.ifReq || bus.dReq;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gntD_d    = gntD_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ifRdata_d = ifRdata_q;
    dRdata_d  = dRdata_q;
`ifdef MEMARB_RR_EN
    rrD_d     = rrD_q;
`endif
    if (state_q == IDLE && anyReq) begin
      gntD_d  = pickD;
      we_d    = pickD && bus.dWe;
      addr_d  = pickD ? bus.dAddr : bus.ifAddr;
      wdata_d = bus.dWdata;
`ifdef MEMARB_RR_EN
      rrD_d   = !pickD;
`endif
    end
    if (state_q == ACCESS && !we_q) begin
      if (gntD_q) dRdata_d  = ramData;
      else        ifRdata_d = ramData;
    end
  end

  // Grant and returned words are architecturally visible, so they reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gntD_q    <= 1'b0;
      ifRdata_q <= '0;
      dRdata_q  <= '0;
`ifdef MEMARB_RR_EN
      rrD_q     <= 1'b0;
`endif
    end else begin
      gntD_q    <= gntD_d;
      ifRdata_q <= ifRdata_d;
      dRdata_q  <= dRdata_d;
`ifdef MEMARB_RR_EN
      rrD_q     <= rrD_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    bus.ramAddr = '0;
    bus.ramRdEn = 1'b0;
    bus.ramWrEn = 1'b0;
    bus.ifAck   = 1'b0;
    bus.dAck    = 1'b0;
    bus.busy    = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        bus.ramAddr = addr_q;
        bus.ramRdEn = !we_q;
        bus.ramWrEn = we_q;
      end
      DONE: begin
        bus.ifAck = !gntD_q;
        bus.dAck  = gntD_q;
      end
      default: ;
    endcase
  end

  assign bus.ifRdata = ifRdata_q;
  assign bus.dRdata  = dRdata_q;

  // Only a store in ACCESS owns the shared data bus.
  assign ramData = (state_q == ACCESS && we_q) ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus reset, tie and held-request sequences.
module tb_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  wire  [DW-1:0] ramData;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .ramData(ramData)
  );

  // RAM model: word at address a starts as {a, ~a}, except 0x10 which holds 0xBEEF.
  logic [DW-1:0] mem [256];
  bit            mem_init;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= {i[7:0], ~i[7:0]};
      mem[8'h10] <= 16'hBEEF;
      mem_init <= 1'b1;
    end else if (bus.ramWrEn) begin
      mem[bus.ramAddr] <= ramData;
    end
  end

  assign ramData = bus.ramRdEn ? mem[bus.ramAddr] : 16'bz;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.ifAck || bus.dAck) && n < 8);
  endtask

  // Bus-level invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_wr_exclusive", {31'b0, bus.ramRdEn & bus.ramWrEn}, 32'd0);
      chk("ack_exclusive", {31'b0, bus.ifAck & bus.dAck}, 32'd0);
      if (!bus.ramRdEn && !bus.ramWrEn)
        chk("bus_released", {31'b0, (ramData === 16'hzzzz) || (ramData === 16'h0000)}, 32'd1);
    end
  end

  typedef struct {
    logic          ifReq;
    logic [AW-1:0] ifAddr;
    logic          dReq;
    logic          dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata;
    logic          expD;
    logic [DW-1:0] expRd;
  } vec_t;

  vec_t vt [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] mdl_if, mdl_d;
    logic [AW-1:0] exp_addr;
    logic          wr, expD;
    int            gap;

    rst = 1'b1;
    bus.ifReq = 1'b0; bus.ifAddr = '0;
    bus.dReq  = 1'b0; bus.dWe = 1'b0; bus.dAddr = '0; bus.dWdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'b0, bus.busy}, 0);
    chk("rst_ifAck",   {31'b0, bus.ifAck}, 0);
    chk("rst_dAck",    {31'b0, bus.dAck}, 0);
    chk("rst_ifRdata", {16'b0, bus.ifRdata}, 0);
    chk("rst_dRdata",  {16'b0, bus.dRdata}, 0);
    chk("rst_ramAddr", {24'b0, bus.ramAddr}, 0);
    chk("rst_ramRdEn", {31'b0, bus.ramRdEn}, 0);
    chk("rst_ramWrEn", {31'b0, bus.ramWrEn}, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    mdl_if = '0;
    mdl_d  = '0;

    //            ifReq ifAddr  dReq dWe dAddr  dWdata    expD expRd
    vt[0] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hBEEF};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 16'h0000};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 16'h1234};
    vt[3] = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1234};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h7F, 16'h0000, 1'b1, 16'h7F80};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 16'h0F0F, 1'b1, 16'h0000};
    vt[6] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0F0F};
    vt[7] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00FF};

    for (int i = 0; i < 8; i++) begin
      bus.ifReq  = vt[i].ifReq;  bus.ifAddr = vt[i].ifAddr;
      bus.dReq   = vt[i].dReq;   bus.dWe    = vt[i].dWe;
      bus.dAddr  = vt[i].dAddr;  bus.dWdata = vt[i].dWdata;
      wr       = vt[i].expD && vt[i].dWe;
      exp_addr = vt[i].expD ? vt[i].dAddr : vt[i].ifAddr;

      step();
      chk("acc_busy",    {31'b0, bus.busy}, 1);
      chk("acc_ramAddr", {24'b0, bus.ramAddr}, {24'b0, exp_addr});
      chk("acc_ramRdEn", {31'b0, bus.ramRdEn}, {31'b0, !wr});
      chk("acc_ramWrEn", {31'b0, bus.ramWrEn}, {31'b0, wr});
      chk("acc_acks",    {30'b0, bus.ifAck, bus.dAck}, 0);
      if (wr) chk("acc_store_data", {16'b0, ramData}, {16'b0, vt[i].dWdata});
      bus.ifAddr = ~vt[i].ifAddr;
      bus.dAddr  = ~vt[i].dAddr;
      bus.dWdata = 16'h5555;
      #1;
      chk("acc_addr_latched", {24'b0, bus.ramAddr}, {24'b0, exp_addr});
      if (wr) chk("acc_wdata_latched", {16'b0, ramData}, {16'b0, vt[i].dWdata});

      step();
      chk("done_ifAck", {31'b0, bus.ifAck}, {31'b0, !vt[i].expD});
      chk("done_dAck",  {31'b0, bus.dAck},  {31'b0, vt[i].expD});
      chk("done_en",    {30'b0, bus.ramRdEn, bus.ramWrEn}, 0);
      chk("done_busy",  {31'b0, bus.busy}, 1);
      if (!wr) begin
        if (vt[i].expD) mdl_d  = vt[i].expRd;
        else            mdl_if = vt[i].expRd;
      end
      chk("done_ifRdata", {16'b0, bus.ifRdata}, {16'b0, mdl_if});
      chk("done_dRdata",  {16'b0, bus.dRdata},  {16'b0, mdl_d});
      bus.ifReq = 1'b0;
      bus.dReq  = 1'b0;

      step();
      chk("idle_busy",    {31'b0, bus.busy}, 0);
      chk("idle_acks",    {30'b0, bus.ifAck, bus.dAck}, 0);
      chk("idle_ifRdata", {16'b0, bus.ifRdata}, {16'b0, mdl_if});
      chk("idle_dRdata",  {16'b0, bus.dRdata},  {16'b0, mdl_d});
    end

    // Reset during a load's ACCESS cycle aborts it without an ack.
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 8'h33;
    step();
    chk("rstop_access_rd", {31'b0, bus.ramRdEn}, 1);
    rst = 1'b1;
    step();
    chk("rstop_busy",    {31'b0, bus.busy}, 0);
    chk("rstop_acks",    {30'b0, bus.ifAck, bus.dAck}, 0);
    chk("rstop_ifRdata", {16'b0, bus.ifRdata}, 0);
    chk("rstop_dRdata",  {16'b0, bus.dRdata}, 0);
    chk("rstop_ramAddr", {24'b0, bus.ramAddr}, 0);
    chk("rstop_en",      {30'b0, bus.ramRdEn, bus.ramWrEn}, 0);
    rst = 1'b0;
    bus.dReq = 1'b0;
    step();
    chk("rstop_no_dAck", {31'b0, bus.dAck}, 0);
    chk("rstop_idle",    {31'b0, bus.busy}, 0);

    // Both ports request continuously for four transactions.
    bus.ifReq = 1'b1; bus.ifAddr = 8'h01;
    bus.dReq  = 1'b1; bus.dWe = 1'b0; bus.dAddr = 8'h02;
    for (int k = 0; k < 4; k++) begin
      wait_ack(gap);
      chk("tie_gap", gap, (k == 0) ? 2 : 3);
`ifdef MEMARB_RR_EN
      expD = (k % 2 == 1);
`else
      expD = 1'b1;
`endif
      chk("tie_dAck",  {31'b0, bus.dAck},  {31'b0, expD});
      chk("tie_ifAck", {31'b0, bus.ifAck}, {31'b0, !expD});
      if (expD) chk("tie_dRdata",  {16'b0, bus.dRdata},  32'h02FD);
      else      chk("tie_ifRdata", {16'b0, bus.ifRdata}, 32'h01FE);
    end
    bus.ifReq = 1'b0;
    bus.dReq  = 1'b0;
    step();
    chk("tie_drain_busy", {31'b0, bus.busy}, 0);

    // Fetch request held across its ack starts a second fetch.
    bus.ifReq = 1'b1; bus.ifAddr = 8'h10;
    wait_ack(gap);
    chk("held_gap1",    gap, 2);
    chk("held_ifAck1",  {31'b0, bus.ifAck}, 1);
    chk("held_ifRdata1", {16'b0, bus.ifRdata}, 32'h0F0F);
    step();
    chk("held_idle", {30'b0, bus.busy, bus.ifAck}, 0);
    step();
    chk("held_access_addr", {24'b0, bus.ramAddr}, 32'h10);
    bus.ifAddr = 8'h55;
    #1;
    chk("held_addr_change", {24'b0, bus.ramAddr}, 32'h10);
    step();
    chk("held_ifAck2",   {31'b0, bus.ifAck}, 1);
    chk("held_dAck2",    {31'b0, bus.dAck}, 0);
    chk("held_ifRdata2", {16'b0, bus.ifRdata}, 32'h0F0F);
    bus.ifReq = 1'b0;
    step();
    chk("held_end_busy", {31'b0, bus.busy}, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
